step_gen: RTL

//  Step/direction pulse generator for one CNC axis. Sits directly downstream of clk_div.
//  It consumes the clk_ena tick strobe and turns a motion command (direction, step count,

---
 rtl/step_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/step_gen.sv
// step_gen: step/dir pulse generator for one CNC axis, timed in clk_ena ticks; STEP_GEN_POS_EN adds a signed position counter.
// Latency: a command is taken in one clk; the first step rises one clk later (same dir) or after DIR_SETUP ticks.
// Backpressure: cmd_ready is high only in IDLE, so a command waits on cmd_valid until the previous one finishes.
module step_gen #(
  parameter int STEP_W    = 32,
  parameter int PER_W     = 16,
  parameter int PULSE_W   = 4,
  parameter int DIR_SETUP = 8
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic              clk_ena,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [PER_W-1:0]  cmd_period,
  input  logic              abort,
`ifdef STEP_GEN_POS_EN
  input  logic              pos_load,
  input  logic [STEP_W-1:0] pos_val,
  output logic [STEP_W-1:0] pos,
`endif
  output logic              step,
  output logic              dir,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, DONE} state_t;

  localparam logic [PER_W-1:0]  PULSE_TICKS = PER_W'(PULSE_W);
  localparam logic [PER_W-1:0]  SETUP_TICKS = PER_W'(DIR_SETUP);
  localparam logic [PER_W-1:0]  MIN_PER     = PER_W'(PULSE_W + 1);
  localparam logic [PER_W-1:0]  ONE         = PER_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);

  state_t            state, state_nxt;
  logic [PER_W-1:0]  cnt, cnt_nxt;
  logic [PER_W-1:0]  per, per_nxt;
  logic [STEP_W-1:0] rem, rem_nxt;
  logic              dir_nxt;
  logic              abort_pend, abort_pend_nxt;
  logic              accept;
  logic              tick_last;

  assign cmd_ready = (state == IDLE) && !sclr;
  assign accept    = cmd_valid && cmd_ready;
  assign tick_last = clk_ena && (cnt == ONE);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    per_nxt        = per;
    rem_nxt        = rem;
    dir_nxt        = dir;
    abort_pend_nxt = abort_pend;
    case (state)
      IDLE: begin
        if (accept) begin
          rem_nxt        = cmd_steps;
          per_nxt        = (cmd_period > PULSE_TICKS) ? cmd_period : MIN_PER;
          dir_nxt        = cmd_dir;
          abort_pend_nxt = 1'b0;
          if (cmd_steps == '0) begin
            state_nxt = DONE;
          end else if (cmd_dir != dir) begin
            state_nxt = SETUP;
            cnt_nxt   = SETUP_TICKS;
          end else begin
            state_nxt = PULSE;
            cnt_nxt   = PULSE_TICKS;
          end
        end
      end
      SETUP: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (tick_last) begin
          state_nxt = PULSE;
          cnt_nxt   = PULSE_TICKS;
        end else if (clk_ena) begin
          cnt_nxt = cnt - ONE;
        end
      end
      PULSE: begin
        // An abort here is remembered so the pulse still runs its full width.
        if (abort) abort_pend_nxt = 1'b1;
        if (tick_last) begin
          rem_nxt = rem - STEP_ONE;
          if (abort || abort_pend) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = GAP;
            cnt_nxt   = per - PULSE_TICKS;
          end
        end else if (clk_ena) begin
          cnt_nxt = cnt - ONE;
        end
      end
      GAP: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (tick_last) begin
          if (rem != '0) begin
            state_nxt = PULSE;
            cnt_nxt   = PULSE_TICKS;
          end else begin
            state_nxt = IDLE;
          end
        end else if (clk_ena) begin
          cnt_nxt = cnt - ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state      <= IDLE;
      cnt        <= '0;
      per        <= '0;
      rem        <= '0;
      dir        <= 1'b0;
      abort_pend <= 1'b0;
      step       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      per        <= per_nxt;
      rem        <= rem_nxt;
      dir        <= dir_nxt;
      abort_pend <= abort_pend_nxt;
      step       <= (state_nxt == PULSE);
      busy       <= (state_nxt != IDLE);
    end
  end

`ifdef STEP_GEN_POS_EN
  logic pulse_entry;
  assign pulse_entry = (state_nxt == PULSE) && (state != PULSE);

  // A load on the same edge as a pulse entry wins; that step is not counted.
  always_ff @(posedge clk) begin
    if (sclr) begin
      pos <= '0;
    end else if (pos_load) begin
      pos <= pos_val;
    end else if (pulse_entry) begin
      pos <= dir_nxt ? (pos + STEP_ONE) : (pos - STEP_ONE);
    end
  end
`endif

endmodule
